// File: rtl/riscv_defs.sv
// Shared RV32I core definitions: fixed encodings, fetch FSM states
// and the IF/ID pipeline bundle.
package riscv_defs;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
   localparam logic [31:0] PC_STEP     = 32'd4;

   localparam logic [1:0] ST_WARM  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: hazard/redirect controls, instruction
// memory port and the IF/ID bundle seen by decode.
interface fetch_stage_if;

   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] read_address;
   logic [31:0] instruction_in;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        halted;
   logic        fault;

   modport master (
      input  stall,
      input  redirect_valid,
      input  redirect_target,
      input  instruction_in,
      output read_address,
      output ifid_valid,
      output ifid_pc,
      output ifid_instr,
      output halted,
      output fault
   );

   modport slave (
      output stall,
      output redirect_valid,
      output redirect_target,
      output instruction_in,
      input  read_address,
      input  ifid_valid,
      input  ifid_pc,
      input  ifid_instr,
      input  halted,
      input  fault
   );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection (redirect > stall > sequential) with the
// alignment / instruction-memory range check on the chosen PC.
module fetch_next_pc
   import riscv_defs::*;
#(
   parameter int unsigned IMEM_WORDS = 64
) (
   input  logic [31:0] i_pc,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_target,
   input  logic        i_stall,
   output logic [31:0] o_next_pc,
   output logic        o_err
);

   localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

   logic [31:0] w_seq_pc;

   assign w_seq_pc = i_pc + PC_STEP;

   always_comb begin
      o_next_pc = i_pc;
      o_err     = 1'b0;
      if (i_redirect_valid) begin
         o_next_pc = i_redirect_target;
         o_err     = (|i_redirect_target[1:0]) ||
                     (i_redirect_target >= LIMIT);
      end else if (!i_stall) begin
         o_next_pc = w_seq_pc;
         o_err     = (w_seq_pc >= LIMIT);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, drives instruction memory
// and fills the IF/ID register; stops on ECALL or a bad PC.
module fetch_stage
   import riscv_defs::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 64
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus
);

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   ifid_t       r_ifid;

   logic [31:0] w_next_pc;
   logic        w_err;
   logic        w_ecall;

   fetch_next_pc #(
      .IMEM_WORDS (IMEM_WORDS)
   ) u_next_pc (
      .i_pc              (r_pc),
      .i_redirect_valid  (bus.redirect_valid),
      .i_redirect_target (bus.redirect_target),
      .i_stall           (bus.stall),
      .o_next_pc         (w_next_pc),
      .o_err             (w_err)
   );

   assign w_ecall = (bus.instruction_in == ECALL_INSTR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_WARM;
         r_pc         <= RESET_PC;
         r_ifid.valid <= 1'b0;
         r_ifid.pc    <= 32'h0;
         r_ifid.instr <= NOP_INSTR;
      end else begin
         unique case (r_state)
            ST_WARM: r_state <= ST_RUN;
            ST_RUN: begin
               if (bus.redirect_valid) begin
                  // Flush the wrong-path word; a bad target keeps the old PC.
                  r_ifid.valid <= 1'b0;
                  r_ifid.instr <= NOP_INSTR;
                  if (w_err) r_state <= ST_FAULT;
                  else       r_pc    <= w_next_pc;
               end else if (!bus.stall) begin
                  r_ifid.valid <= 1'b1;
                  r_ifid.pc    <= r_pc;
                  r_ifid.instr <= bus.instruction_in;
                  if (w_ecall)    r_state <= ST_HALT;
                  else if (w_err) r_state <= ST_FAULT;
                  else            r_pc    <= w_next_pc;
               end
            end
            default: begin
               r_ifid.valid <= 1'b0;
               r_ifid.instr <= NOP_INSTR;
            end
         endcase
      end
   end

   assign bus.read_address = r_pc;
   assign bus.ifid_valid   = r_ifid.valid;
   assign bus.ifid_pc      = r_ifid.pc;
   assign bus.ifid_instr   = r_ifid.instr;
   assign bus.halted       = (r_state == ST_HALT);
   assign bus.fault        = (r_state == ST_FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run
// against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam int M_WARM = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC   (32'h0),
      .IMEM_WORDS (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] mem [64];

   assign bus.instruction_in = (bus.read_address < 32'd256) ?
                               mem[bus.read_address[7:2]] : 32'h0;

   logic [98:0] obs;
   assign obs = {bus.read_address, bus.ifid_valid, bus.ifid_pc,
                 bus.ifid_instr, bus.halted, bus.fault};

   int checks = 0;
   int failures = 0;

   int          m_mode;
   logic [31:0] m_pc, m_ipc, m_instr;
   logic        m_v;
   logic [98:0] exp;

   task automatic drive(input logic st, input logic rv,
                        input logic [31:0] tgt);
      bus.stall           = st;
      bus.redirect_valid  = rv;
      bus.redirect_target = tgt;
   endtask

   task automatic model_reset();
      m_mode = M_WARM; m_pc = 0; m_ipc = 0; m_instr = NOP; m_v = 0;
   endtask

   // Advance the reference model with the inputs now applied, then clock.
   task automatic tick();
      logic [31:0] w;
      case (m_mode)
         M_WARM: m_mode = M_RUN;
         M_RUN: begin
            if (bus.redirect_valid) begin
               m_v = 0; m_instr = NOP;
               if (bus.redirect_target % 4 != 0 || bus.redirect_target >= 256)
                  m_mode = M_FAULT;
               else
                  m_pc = bus.redirect_target;
            end else if (!bus.stall) begin
               w = mem[m_pc / 4];
               m_v = 1; m_ipc = m_pc; m_instr = w;
               if (w == ECALL) m_mode = M_HALT;
               else if (m_pc + 4 >= 256) m_mode = M_FAULT;
               else m_pc = m_pc + 4;
            end
         end
         default: begin m_v = 0; m_instr = NOP; end
      endcase
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drive(0, 0, 0);
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic load_prog();
      for (int i = 0; i < 64; i++)
         mem[i] = {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
      mem[8] = ECALL;
   endtask

   task automatic test_reset_and_run();
      do_reset();
      exp = {32'h0, 1'b0, 32'h0, NOP, 2'b00};
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp);
      end
      tick();
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL warm_no_capture got=%h exp=%h", obs, exp);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         exp = {32'(4 * i + 4), 1'b1, 32'(4 * i), mem[i], 2'b00};
         checks++;
         if (obs !== exp) begin
            failures++; $display("FAIL seq_fetch%0d got=%h exp=%h", i, obs, exp);
         end
      end
   endtask

   task automatic test_stall();
      drive(1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         exp = {32'h0C, 1'b1, 32'h08, mem[2], 2'b00};
         checks++;
         if (obs !== exp) begin
            failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, exp);
         end
      end
      drive(0, 0, 0);
      tick();
      exp = {32'h10, 1'b1, 32'h0C, mem[3], 2'b00};
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL stall_release got=%h exp=%h", obs, exp);
      end
      tick(); tick();
   endtask

   task automatic test_redirect();
      drive(0, 1, 32'h0C);
      tick();
      checks++;
      if ({bus.read_address, bus.ifid_valid, bus.ifid_instr, bus.halted,
           bus.fault} !== {32'h0C, 1'b0, NOP, 2'b00}) begin
         failures++;
         $display("FAIL redirect_flush got=%h/%b/%h", bus.read_address,
                  bus.ifid_valid, bus.ifid_instr);
      end
      drive(0, 0, 0);
      tick();
      exp = {32'h10, 1'b1, 32'h0C, mem[3], 2'b00};
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL redirect_target got=%h exp=%h", obs, exp);
      end
   endtask

   task automatic test_ecall();
      for (int i = 0; i < 4; i++) tick();
      tick();
      exp = {32'h20, 1'b1, 32'h20, ECALL, 2'b10};
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL ecall_capture got=%h exp=%h", obs, exp);
      end
      tick();
      exp = {32'h20, 1'b0, 32'h20, NOP, 2'b10};
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL halt_state got=%h exp=%h", obs, exp);
      end
      drive(0, 1, 32'h04);
      tick();
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL halt_ignores_redirect got=%h exp=%h", obs, exp);
      end
   endtask

   task automatic test_fault();
      do_reset(); tick();
      drive(0, 1, 32'h0E);
      tick();
      exp = {32'h0, 1'b0, 32'h0, NOP, 2'b01};
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL fault_misaligned got=%h exp=%h", obs, exp);
      end
      drive(0, 1, 32'h08);
      tick();
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL fault_sticky got=%h exp=%h", obs, exp);
      end
      do_reset(); tick();
      drive(0, 1, 32'h100);
      tick();
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL fault_range got=%h exp=%h", obs, exp);
      end
      do_reset(); tick();
      drive(0, 1, 32'hFC);
      tick();
      drive(0, 0, 0);
      tick();
      exp = {32'hFC, 1'b1, 32'hFC, mem[63], 2'b01};
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL fault_last_word got=%h exp=%h", obs, exp);
      end
   endtask

   task automatic test_redirect_priority();
      do_reset(); tick();
      drive(0, 1, 32'h20);
      tick();
      drive(1, 1, 32'h04);
      tick();
      exp = {32'h04, 1'b0, 32'h0, NOP, 2'b00};
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL redirect_over_ecall_stall got=%h exp=%h", obs, exp);
      end
      drive(0, 0, 0);
      tick();
      exp = {32'h08, 1'b1, 32'h04, mem[1], 2'b00};
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL after_priority got=%h exp=%h", obs, exp);
      end
   endtask

   task automatic test_async_reset();
      do_reset(); tick();
      drive(0, 1, 32'h14);
      tick();
      drive(1, 0, 0);
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      exp = {32'h0, 1'b0, 32'h0, NOP, 2'b00};
      checks++;
      if (obs !== exp) begin
         failures++; $display("FAIL async_reset got=%h exp=%h", obs, exp);
      end
      do_reset();
   endtask

   task automatic test_random();
      logic [31:0] w, tgt;
      int stuck = 0;
      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         if ($urandom_range(15) == 0) w = ECALL;
         else if (w == ECALL) w = NOP;
         mem[i] = w;
      end
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3) == 0) tgt = 32'($urandom_range(0, 300));
         else tgt = 32'($urandom_range(0, 63) * 4);
         drive(($urandom_range(3) == 0), ($urandom_range(5) == 0), tgt);
         tick();
         exp = {m_pc, m_v, m_ipc, m_instr, (m_mode == M_HALT),
                (m_mode == M_FAULT)};
         checks++;
         if (obs !== exp) begin
            failures++; $display("FAIL random_c%0d got=%h exp=%h", c, obs, exp);
         end
         stuck = (m_mode >= M_HALT) ? stuck + 1 : 0;
         if (stuck > 2) begin
            do_reset();
            stuck = 0;
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 0, 0);
      load_prog();
      test_reset_and_run();
      test_stall();
      test_redirect();
      test_ecall();
      test_fault();
      test_redirect_priority();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
